// File: rtl/mem_access_arbiter.sv
// Two-requester round-robin front end for a strobe-triggered memory.
// Fields are registered at grant and held SETUP_CYC clocks before m_start rises.
module mem_access_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              m_start,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);

    generate
        if (SETUP_CYC < 1) begin : g_bad_setup
            $error("SETUP_CYC must be at least 1");
        end
        if (STROBE_CYC < 1) begin : g_bad_strobe
            $error("STROBE_CYC must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             owner;  // last granted requester; doubles as the RR pointer
    logic             pick1;

    // Contention goes to whoever was not granted last.
    always_comb begin
        pick1 = req1;
        if (req0 && req1) begin
            pick1 = ~owner;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            owner   <= 1'b1;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            rdata   <= '0;
            m_start <= 1'b0;
            m_write <= 1'b0;
            m_addr  <= '0;
            m_data  <= '0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state   <= SETUP;
                        cnt     <= '0;
                        owner   <= pick1;
                        gnt0    <= ~pick1;
                        gnt1    <= pick1;
                        m_write <= pick1 ? we1 : we0;
                        m_addr  <= pick1 ? addr1 : addr0;
                        m_data  <= pick1 ? wdata1 : wdata0;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        state   <= STROBE;
                        cnt     <= '0;
                        m_start <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STROBE: begin
                    if (cnt == STROBE_LAST) begin
                        state   <= HOLD;
                        cnt     <= '0;
                        m_start <= 1'b0;
                        done0   <= ~owner;
                        done1   <= owner;
                        if (!m_write) begin
                            rdata <= m_rdata;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    state   <= IDLE;
                    m_write <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: default-timing instance plus a
// SETUP_CYC=3/STROBE_CYC=2 instance, each with a behavioural strobe memory.
module tb_mem_access_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [7:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic       gnt0, gnt1, done0, done1, busy, m_start, m_write;
    logic [7:0] rdata, m_addr, m_data, m_rdata;

    logic       b_req0 = 0, b_we0 = 0;
    logic [7:0] b_addr0 = 0, b_wdata0 = 0;
    logic       b_gnt0, b_gnt1, b_done0, b_done1, b_busy, b_start, b_write;
    logic [7:0] b_rdata, b_addr, b_data, b_mrdata;

    logic [7:0] mem1 [256];
    logic [7:0] mem2 [256];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_arbiter u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .busy(busy),
        .m_start(m_start), .m_write(m_write), .m_addr(m_addr), .m_data(m_data),
        .m_rdata(m_rdata)
    );

    mem_access_arbiter #(.SETUP_CYC(3), .STROBE_CYC(2)) u_slow (
        .clk(clk), .rst(rst),
        .req0(b_req0), .req1(1'b0), .we0(b_we0), .we1(1'b0),
        .addr0(b_addr0), .addr1(8'h00), .wdata0(b_wdata0), .wdata1(8'h00),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1),
        .rdata(b_rdata), .busy(b_busy),
        .m_start(b_start), .m_write(b_write), .m_addr(b_addr), .m_data(b_data),
        .m_rdata(b_mrdata)
    );

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 8'h00;
            mem2[i] = 8'h00;
        end
        m_rdata  = 8'h00;
        b_mrdata = 8'h00;
    end

    // Memories act only on the rising edge of their strobe.
    always @(posedge m_start) begin
        if (m_write) mem1[m_addr] = m_data;
        else         m_rdata = mem1[m_addr];
    end

    always @(posedge b_start) begin
        if (b_write) mem2[b_addr] = b_data;
        else         b_mrdata = mem2[b_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Mutual-exclusion properties sampled every cycle away from the edge.
    always @(negedge clk) begin
        check("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
        check("done_excl", 32'(done0 & done1), 32'd0);
        check("start_idle", 32'(m_start & ~busy), 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(m_start), 32'd0);
        check("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
        check("rst_done", 32'({done0, done1}), 32'd0);
        check("rst_fields", 32'({m_write, m_addr, m_data, rdata}), 32'd0);
        rst = 1'b0;

        // Single write from requester 0 (cycle T)
        req0 = 1; we0 = 1; addr0 = 8'h42; wdata0 = 8'h5a;
        tick();
        check("w_gnt0", 32'({gnt0, gnt1}), 32'b10);
        check("w_fields", 32'({m_write, m_addr, m_data}), {15'd0, 1'b1, 8'h42, 8'h5a});
        check("w_setup_start", 32'(m_start), 32'd0);
        check("w_busy", 32'(busy), 32'd1);
        tick();
        check("w_strobe", 32'(m_start), 32'd1);
        check("w_gnt_pulse", 32'(gnt0), 32'd0);
        tick();
        check("w_done", 32'({done0, done1, m_start}), 32'b100);
        check("w_rdata_hold", 32'(rdata), 32'd0);
        req0 = 0;
        tick();
        check("w_idle", 32'({busy, m_write, m_start}), 32'd0);
        check("w_addr_kept", 32'(m_addr), 32'h42);
        check("w_mem", 32'(mem1[8'h42]), 32'h5a);

        // Read-back by requester 1
        req1 = 1; we1 = 0; addr1 = 8'h42;
        tick();
        check("r_gnt1", 32'({gnt0, gnt1, m_write}), 32'b010);
        tick();
        check("r_strobe", 32'({m_start, m_write}), 32'b10);
        tick();
        check("r_done1", 32'({done0, done1}), 32'b01);
        check("r_rdata", 32'(rdata), 32'h5a);
        req1 = 0;
        tick();
        check("r_idle", 32'(busy), 32'd0);

        // Contention from reset: 0,1,0,1 four cycles apart
        rst = 1;
        req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 8'h01;
        req1 = 1; we1 = 1; addr1 = 8'h11; wdata1 = 8'h02;
        tick();
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("c_gnt", 32'({gnt0, gnt1}), (k % 2 == 0) ? 32'b10 : 32'b01);
            tick();
            check("c_strobe", 32'(m_start), 32'd1);
            tick();
            check("c_done", 32'({done0, done1}), (k % 2 == 0) ? 32'b10 : 32'b01);
            tick();
            check("c_idle", 32'({busy, m_start}), 32'd0);
            if (k == 3) begin
                req0 = 0;
                req1 = 0;
            end
        end
        tick();
        check("c_quiet", 32'(busy), 32'd0);
        check("c_mem0", 32'(mem1[8'h10]), 32'h01);
        check("c_mem1", 32'(mem1[8'h11]), 32'h02);
        check("c_rdata_hold", 32'(rdata), 32'd0);

        // Fields stable after grant
        req0 = 1; we0 = 1; addr0 = 8'h22; wdata0 = 8'haa;
        tick();
        check("f_gnt", 32'(gnt0), 32'd1);
        addr0 = 8'h33; wdata0 = 8'hbb; we0 = 0;
        tick();
        check("f_fields_strobe", 32'({m_write, m_addr, m_data}), {15'd0, 1'b1, 8'h22, 8'haa});
        tick();
        check("f_fields_hold", 32'({m_addr, m_data, done0}), {15'd0, 8'h22, 8'haa, 1'b1});
        req0 = 0;
        tick();
        check("f_mem22", 32'(mem1[8'h22]), 32'haa);
        check("f_mem33", 32'(mem1[8'h33]), 32'h00);

        // Reset while strobing
        req0 = 1; we0 = 1; addr0 = 8'h50; wdata0 = 8'h77;
        tick();
        tick();
        check("x_in_strobe", 32'(m_start), 32'd1);
        #3 rst = 1;
        #1;
        check("x_async", 32'({m_start, busy, gnt0, gnt1, done0, done1}), 32'd0);
        req0 = 0;
        tick();
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("x_no_done", 32'({done0, done1, busy}), 32'd0);
        end
        req0 = 1; req1 = 1; we0 = 0; we1 = 0;
        tick();
        check("x_first_gnt", 32'({gnt0, gnt1}), 32'b10);
        tick();
        tick();
        check("x_done", 32'(done0), 32'd1);
        req0 = 0; req1 = 0;
        tick();

        // SETUP_CYC=3, STROBE_CYC=2 instance
        b_req0 = 1; b_we0 = 1; b_addr0 = 8'h07; b_wdata0 = 8'h99;
        tick();
        check("s_gnt", 32'({b_gnt0, b_start}), 32'b10);
        tick();
        check("s_setup2", 32'({b_start, b_busy}), 32'b01);
        tick();
        check("s_setup3", 32'(b_start), 32'd0);
        tick();
        check("s_strobe1", 32'(b_start), 32'd1);
        tick();
        check("s_strobe2", 32'({b_start, b_done0}), 32'b10);
        tick();
        check("s_done", 32'({b_start, b_done0}), 32'b01);
        b_req0 = 0;
        tick();
        check("s_idle", 32'({b_busy, b_done0}), 32'd0);
        check("s_mem", 32'(mem2[8'h07]), 32'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
